mem_responder: RTL and testbench

MEM_RESPONDER -- requirements
Module: mem_responder

---
 rtl/mem_responder.sv | 112 +++++++++++
 tb/tb_mem_responder.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_responder.sv
// Memory-mapped responder: a byte-wide RAM with a registered read port, plus a
// small IO region that feeds a TX byte FIFO and exposes a status byte.
// IO region is mem_a[17:16] == 2'b11. The TX data port is 0x30000 and the
// status port is 0x30004. The status byte is {6'b0, overflow, full}.
module mem_responder #(
  parameter int ADDR_WIDTH = 17,
  parameter int FIFO_DEPTH = 8
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic        mem_wr,
  input  logic [31:0] mem_a,
  input  logic [7:0]  mem_dout,
  output logic [7:0]  mem_din,
  output logic        io_buffer_full,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready
);

  localparam int IDX_W = $clog2(FIFO_DEPTH);
  localparam int PTR_W = IDX_W + 1;
  localparam logic [PTR_W-1:0] ALMOST_FULL = PTR_W'(FIFO_DEPTH - 1);
  localparam logic [31:0] TX_ADDR     = 32'h0003_0000;
  localparam logic [31:0] STATUS_ADDR = 32'h0003_0004;

  // RAM contents survive reset, so the array carries no reset.
  logic [7:0] ram [0:(1 << ADDR_WIDTH) - 1];
  logic [7:0] fifo_mem [0:FIFO_DEPTH-1];

  logic [PTR_W-1:0]      wr_ptr_reg, wr_ptr_next;
  logic [PTR_W-1:0]      rd_ptr_reg, rd_ptr_next;
  logic [PTR_W-1:0]      occupancy;
  logic                  overflow_reg, overflow_next;
  logic                  io_sel, ram_we, mem_re;
  logic                  push_req, push, pop;
  logic                  empty, full;
  logic [ADDR_WIDTH-1:0] ram_idx;
  logic [7:0]            status_byte;

  // Address decode, FIFO handshake and next-state computation.
  always_comb begin
    io_sel        = (mem_a[17:16] == 2'b11);
    ram_idx       = mem_a[ADDR_WIDTH-1:0];
    ram_we        = rdy_in && mem_wr && !io_sel;
    mem_re        = rdy_in && !mem_wr;
    push_req      = rdy_in && mem_wr && (mem_a == TX_ADDR);

    occupancy     = wr_ptr_reg - rd_ptr_reg;
    empty         = (wr_ptr_reg == rd_ptr_reg);
    full          = (wr_ptr_reg[PTR_W-1] != rd_ptr_reg[PTR_W-1]) &&
                    (wr_ptr_reg[PTR_W-2:0] == rd_ptr_reg[PTR_W-2:0]);

    // Pops ignore rdy_in. A pop in the same cycle frees a slot for a push
    // that arrives while the FIFO is full.
    pop           = !empty && tx_ready;
    push          = push_req && (!full || pop);

    wr_ptr_next   = push ? wr_ptr_reg + PTR_W'(1) : wr_ptr_reg;
    rd_ptr_next   = pop  ? rd_ptr_reg + PTR_W'(1) : rd_ptr_reg;
    overflow_next = overflow_reg || (push_req && full && !pop);

    status_byte   = {6'b0, overflow_reg, full};
  end

  assign tx_valid       = !empty;
  assign tx_data        = fifo_mem[rd_ptr_reg[PTR_W-2:0]];
  assign io_buffer_full = (occupancy >= ALMOST_FULL);

  // RAM write port.
  always_ff @(posedge clk_in) begin
    if (ram_we) begin
      ram[ram_idx] <= mem_dout;
    end
  end

  // FIFO storage. When full, the tail slot is also the head slot. It can only
  // be written together with a pop, which consumes the old head at this edge.
  always_ff @(posedge clk_in) begin
    if (push) begin
      fifo_mem[wr_ptr_reg[PTR_W-2:0]] <= mem_dout;
    end
  end

  // Registered read data. The value holds on writes and on stalled cycles.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      mem_din <= 8'h00;
    end else if (mem_re) begin
      if (io_sel) begin
        mem_din <= (mem_a == STATUS_ADDR) ? status_byte : 8'h00;
      end else begin
        mem_din <= ram[ram_idx];
      end
    end
  end

  // FIFO pointers and the sticky overflow flag. Reset discards queued bytes.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      overflow_reg <= 1'b0;
    end else begin
      wr_ptr_reg   <= wr_ptr_next;
      rd_ptr_reg   <= rd_ptr_next;
      overflow_reg <= overflow_next;
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// Testbench for mem_responder. Directed scenarios come first, followed by
// randomized traffic. Both are checked against a queue/array reference model.
module tb_mem_responder;

  localparam int AW    = 17;
  localparam int DEPTH = 8;

  logic        clk_in   = 1'b0;
  logic        rst_in   = 1'b0;
  logic        rdy_in   = 1'b0;
  logic        mem_wr   = 1'b0;
  logic [31:0] mem_a    = 32'h0;
  logic [7:0]  mem_dout = 8'h00;
  logic        tx_ready = 1'b0;
  logic [7:0]  mem_din;
  logic        io_buffer_full;
  logic [7:0]  tx_data;
  logic        tx_valid;

  mem_responder #(.ADDR_WIDTH(AW), .FIFO_DEPTH(DEPTH)) dut (
    .clk_in         (clk_in),
    .rst_in         (rst_in),
    .rdy_in         (rdy_in),
    .mem_wr         (mem_wr),
    .mem_a          (mem_a),
    .mem_dout       (mem_dout),
    .mem_din        (mem_din),
    .io_buffer_full (io_buffer_full),
    .tx_data        (tx_data),
    .tx_valid       (tx_valid),
    .tx_ready       (tx_ready)
  );

  initial forever #5 clk_in = ~clk_in;

  // Reference model state.
  logic [7:0] ram_m [int];
  logic [7:0] q [$];
  logic       ov_m;
  logic [7:0] din_m;

  int pass_cnt = 0;
  int fail_cnt = 0;
  int total    = 0;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
    end
  endtask

  task automatic reset_model();
    q.delete();
    ov_m  = 1'b0;
    din_m = 8'h00;
  endtask

  // Apply the current inputs to the model as if the next rising edge happened.
  task automatic model_step();
    logic pop, push, io;
    int   idx;
    pop  = (q.size() != 0) && tx_ready;
    push = 1'b0;
    io   = (mem_a[17:16] == 2'b11);
    idx  = int'(mem_a[16:0]);
    if (rdy_in) begin
      if (mem_wr) begin
        if (!io) ram_m[idx] = mem_dout;
        else if (mem_a == 32'h30000) begin
          if (q.size() < DEPTH || pop) push = 1'b1;
          else ov_m = 1'b1;
        end
      end else begin
        if (!io) din_m = ram_m[idx];
        else if (mem_a == 32'h30004) din_m = {6'b0, ov_m, (q.size() == DEPTH)};
        else din_m = 8'h00;
      end
    end
    if (pop) void'(q.pop_front());
    if (push) q.push_back(mem_dout);
  endtask

  task automatic check_outputs();
    chk("mem_din", mem_din, din_m);
    chk("tx_valid", {7'b0, tx_valid}, {7'b0, (q.size() != 0)});
    if (q.size() != 0) chk("tx_data", tx_data, q[0]);
    chk("io_buffer_full", {7'b0, io_buffer_full}, {7'b0, (q.size() >= DEPTH - 1)});
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk_in);
    #1;
    check_outputs();
  endtask

  task automatic wr_op(input logic [31:0] a, input logic [7:0] d);
    rdy_in = 1'b1; mem_wr = 1'b1; mem_a = a; mem_dout = d;
    cycle();
    $display("write a=%05h d=%02h tx_ready=%0b -> tx_valid=%0b full_flag=%0b", a, d, tx_ready, tx_valid, io_buffer_full);
  endtask

  task automatic rd_op(input logic [31:0] a);
    rdy_in = 1'b1; mem_wr = 1'b0; mem_a = a;
    cycle();
    $display("read  a=%05h -> mem_din=%02h (model %02h)", a, mem_din, din_m);
  endtask

  task automatic idle();
    rdy_in = 1'b0; mem_wr = 1'b0;
    cycle();
    $display("idle tx_ready=%0b -> tx_valid=%0b tx_data=%02h", tx_ready, tx_valid, tx_data);
  endtask

  // Assert reset between clock edges and check the outputs before any edge.
  // Then hold reset through one edge and release it mid-cycle.
  task automatic async_reset();
    #2 rst_in = 1'b0;
    #1;
    reset_model();
    chk("rst_tx_valid", {7'b0, tx_valid}, 8'h00);
    chk("rst_mem_din", mem_din, 8'h00);
    chk("rst_io_full", {7'b0, io_buffer_full}, 8'h00);
    @(posedge clk_in);
    #1;
    check_outputs();
    #3 rst_in = 1'b1;
    $display("async reset applied and released");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a;
    int          r;

    // Reset state, checked before any clock edge.
    reset_model();
    #1;
    check_outputs();
    #11 rst_in = 1'b1;

    // Give the RAM locations used later a known value.
    for (int i = 0; i < 64; i++) begin
      wr_op(32'(i), 8'($urandom));
      wr_op(32'h10000 + 32'(i), 8'($urandom));
    end

    // Write, then read back on the next cycle.
    wr_op(32'h10, 8'hA5);
    rd_op(32'h10);
    chk("wr_rd_A5", mem_din, 8'hA5);

    // A stalled write is lost, and mem_din holds during the stall.
    wr_op(32'h20, 8'h77);
    rd_op(32'h10);
    rdy_in = 1'b0; mem_wr = 1'b1; mem_a = 32'h20; mem_dout = 8'h3C;
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("stall_hold", mem_din, 8'hA5);
    end
    rd_op(32'h20);
    chk("stall_old", mem_din, 8'h77);

    // Fill the FIFO: the almost-full flag, then the full status.
    tx_ready = 1'b0;
    for (int i = 0; i < 7; i++) begin
      wr_op(32'h30000, 8'(i + 1));
      if (i == 5) chk("almost_full_6", {7'b0, io_buffer_full}, 8'h00);
    end
    chk("almost_full_7", {7'b0, io_buffer_full}, 8'h01);
    rd_op(32'h30004);
    chk("status_7", mem_din, 8'h00);
    wr_op(32'h30000, 8'h08);
    rd_op(32'h30004);
    chk("status_full", mem_din, 8'h01);

    // Push while full: accepted with a simultaneous pop, dropped without one.
    tx_ready = 1'b1;
    wr_op(32'h30000, 8'hFF);
    tx_ready = 1'b0;
    rd_op(32'h30004);
    chk("status_pushpop", mem_din, 8'h01);
    wr_op(32'h30000, 8'hEE);
    rd_op(32'h30004);
    chk("status_ovf", mem_din, 8'h03);

    // Drain the FIFO with rdy_in low.
    tx_ready = 1'b1;
    for (int i = 0; i < DEPTH; i++) idle();
    chk("drained", {7'b0, tx_valid}, 8'h00);

    // Streaming: each byte appears for one cycle, in order.
    wr_op(32'h30000, 8'h11);
    chk("stream_11", tx_data, 8'h11);
    wr_op(32'h30000, 8'h22);
    chk("stream_22", tx_data, 8'h22);
    wr_op(32'h30000, 8'h33);
    chk("stream_33", tx_data, 8'h33);
    idle();
    chk("stream_end", {7'b0, tx_valid}, 8'h00);

    // Reset with bytes queued. The FIFO and overflow clear, and the RAM is kept.
    tx_ready = 1'b0;
    wr_op(32'h40, 8'h5A);
    for (int i = 0; i < 4; i++) wr_op(32'h30000, 8'(8'h50 + i));
    rd_op(32'h10);
    async_reset();
    rd_op(32'h40);
    chk("ram_kept", mem_din, 8'h5A);
    rd_op(32'h30004);
    chk("status_after_rst", mem_din, 8'h00);

    // Randomized traffic. Drain pressure alternates every 200 cycles.
    for (int n = 0; n < 3000; n++) begin
      if (n == 1500) async_reset();
      r = $urandom_range(0, 9);
      case (r)
        0, 1:    a = 32'($urandom_range(0, 63));
        2:       a = 32'h10000 + 32'($urandom_range(0, 63));
        3:       a = 32'h20000 + 32'($urandom_range(0, 63));
        4, 5, 6: a = 32'h30000;
        7:       a = 32'h30004;
        8:       a = 32'h30008;
        default: a = 32'h3FFFF;
      endcase
      rdy_in   = ($urandom_range(0, 3) != 0);
      mem_wr   = $urandom_range(0, 1) == 1;
      mem_a    = a;
      mem_dout = 8'($urandom);
      tx_ready = ($urandom_range(0, 99) < (((n / 200) % 2 == 1) ? 70 : 20));
      cycle();
      $display("rand %0d rdy=%0b wr=%0b a=%05h d=%02h txr=%0b -> din=%02h txv=%0b txd=%02h full_flag=%0b",
               n, rdy_in, mem_wr, a, mem_dout, tx_ready, mem_din, tx_valid, tx_data, io_buffer_full);
    end

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
